// File: rtl/sram_access_seq.sv
// Read/write access sequencer for a 64K x 16 async SRAM: ready/valid request in, registered CS/OE/WE strobes and data bus control out.
// Optional `SRAM_SEQ_AUTOINC_EN adds an auto-incrementing address pointer (PTR_LOAD / REQ_INC).
module sram_access_seq #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int WAIT_CYC = 2,
   parameter int TURN_CYC = 1
) (
   input  logic              CLK,
   input  logic              RST,
`ifdef SRAM_SEQ_AUTOINC_EN
   input  logic              PTR_LOAD,
   input  logic              REQ_INC,
`endif
   input  logic              REQ,
   input  logic              REQ_WR,
   input  logic [ADDR_W-1:0] REQ_ADDR,
   input  logic [DATA_W-1:0] REQ_WDATA,
   output logic              REQ_READY,
   output logic              RD_VALID,
   output logic [DATA_W-1:0] RD_DATA,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   output logic [DATA_W-1:0] DQ_OUT,
   output logic              DQ_OE,
   input  logic [DATA_W-1:0] DQ_IN,
   output logic              CS_BAR_OUT,
   output logic              OE_BAR_OUT,
   output logic              WE_BAR_OUT
);

   localparam int CNT_MAX = (WAIT_CYC > TURN_CYC) ? WAIT_CYC : TURN_CYC;
   localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

   generate
      if (WAIT_CYC < 1) begin : g_bad_wait
         $error("sram_access_seq: WAIT_CYC must be >= 1");
      end
   endgenerate

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, TURN} state_t;

   state_t             state;
   logic               cur_wr;
   logic [CNT_W-1:0]   wait_cnt;
   logic [ADDR_W-1:0]  acc_addr;

`ifdef SRAM_SEQ_AUTOINC_EN
   logic [ADDR_W-1:0]  ptr;

   // A load on the accept edge wins: the access uses REQ_ADDR directly.
   always_comb begin
      acc_addr = REQ_ADDR;
      if (REQ_INC && !PTR_LOAD) acc_addr = ptr;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         ptr <= '0;
      end else if (state == IDLE) begin
         if (REQ && PTR_LOAD)      ptr <= REQ_ADDR + ADDR_W'(1);
         else if (REQ && REQ_INC)  ptr <= ptr + ADDR_W'(1);
         else if (PTR_LOAD)        ptr <= REQ_ADDR;
      end
   end
`else
   assign acc_addr = REQ_ADDR;
`endif

   // NOTE: every register here uses <= so all outputs update together from pre-edge values;
   // synchronous reset also clears the read/address/data registers so nothing leaks across a reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         cur_wr     <= 1'b0;
         wait_cnt   <= '0;
         REQ_READY  <= 1'b1;
         RD_VALID   <= 1'b0;
         RD_DATA    <= '0;
         SRAM_ADDR  <= '0;
         DQ_OUT     <= '0;
         DQ_OE      <= 1'b0;
         CS_BAR_OUT <= 1'b1;
         OE_BAR_OUT <= 1'b1;
         WE_BAR_OUT <= 1'b1;
      end else begin
         RD_VALID <= 1'b0;
         case (state)
            IDLE: begin
               if (REQ) begin
                  state      <= SETUP;
                  cur_wr     <= REQ_WR;
                  REQ_READY  <= 1'b0;
                  SRAM_ADDR  <= acc_addr;
                  CS_BAR_OUT <= 1'b0;
                  DQ_OE      <= REQ_WR;
                  OE_BAR_OUT <= REQ_WR;
                  if (REQ_WR) DQ_OUT <= REQ_WDATA;
               end
            end
            SETUP: begin
               state    <= STROBE;
               wait_cnt <= CNT_W'(WAIT_CYC - 1);
               if (cur_wr) WE_BAR_OUT <= 1'b0;
            end
            STROBE: begin
               if (wait_cnt == '0) begin
                  state      <= HOLD;
                  WE_BAR_OUT <= 1'b1;
                  OE_BAR_OUT <= 1'b1;
                  if (!cur_wr) begin
                     RD_DATA  <= DQ_IN;
                     RD_VALID <= 1'b1;
                  end
               end else begin
                  wait_cnt <= wait_cnt - CNT_W'(1);
               end
            end
            HOLD: begin
               CS_BAR_OUT <= 1'b1;
               DQ_OE      <= 1'b0;
               if (TURN_CYC == 0) begin
                  state     <= IDLE;
                  REQ_READY <= 1'b1;
               end else begin
                  state    <= TURN;
                  wait_cnt <= CNT_W'(TURN_CYC - 1);
               end
            end
            TURN: begin
               if (wait_cnt == '0) begin
                  state     <= IDLE;
                  REQ_READY <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_access_seq.sv
// Randomized bench for sram_access_seq: a per-access timeline model plus an async SRAM model.
// Also exercises the pointer feature when `SRAM_SEQ_AUTOINC_EN is defined.
module tb_sram_access_seq;

   localparam int W    = 2;
   localparam int T    = 1;
   localparam int BUSY = 2 + W + T;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        REQ = 1'b0;
   logic        REQ_WR = 1'b0;
   logic [15:0] REQ_ADDR = '0;
   logic [15:0] REQ_WDATA = '0;
   logic        PTR_LOAD = 1'b0;
   logic        REQ_INC = 1'b0;
   logic        REQ_READY, RD_VALID, DQ_OE;
   logic [15:0] RD_DATA, SRAM_ADDR, DQ_OUT;
   logic [15:0] DQ_IN = '0;
   logic        CS_BAR_OUT, OE_BAR_OUT, WE_BAR_OUT;

   sram_access_seq #(.ADDR_W(16), .DATA_W(16), .WAIT_CYC(W), .TURN_CYC(T)) dut (
      .CLK        (CLK),
      .RST        (RST),
`ifdef SRAM_SEQ_AUTOINC_EN
      .PTR_LOAD   (PTR_LOAD),
      .REQ_INC    (REQ_INC),
`endif
      .REQ        (REQ),
      .REQ_WR     (REQ_WR),
      .REQ_ADDR   (REQ_ADDR),
      .REQ_WDATA  (REQ_WDATA),
      .REQ_READY  (REQ_READY),
      .RD_VALID   (RD_VALID),
      .RD_DATA    (RD_DATA),
      .SRAM_ADDR  (SRAM_ADDR),
      .DQ_OUT     (DQ_OUT),
      .DQ_OE      (DQ_OE),
      .DQ_IN      (DQ_IN),
      .CS_BAR_OUT (CS_BAR_OUT),
      .OE_BAR_OUT (OE_BAR_OUT),
      .WE_BAR_OUT (WE_BAR_OUT)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int rd_pulses = 0;

   // Physical SRAM contents and the bench's idea of what they should be.
   logic [15:0] sram    [logic [15:0]];
   logic [15:0] ref_mem [logic [15:0]];
   logic [15:0] pool [8] = '{16'h0000, 16'h00FF, 16'h1234, 16'h8000,
                             16'hFFFE, 16'hFFFF, 16'h5555, 16'hAAAA};

   // Model: mk = cycle index within the current access (0 = idle).
   int          mk = 0;
   logic        m_wr = 1'b0;
   logic [15:0] m_addr = '0, m_data = '0, m_rd_data = '0, m_sram_addr = '0, m_ptr = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic step(input logic rst_i, input logic req_i, input logic wr_i,
                       input logic [15:0] addr_i, input logic [15:0] data_i,
                       input logic ld_i, input logic inc_i);
      logic exp_cs, exp_we, exp_oe, exp_dqoe, exp_rv;
      RST = rst_i; REQ = req_i; REQ_WR = wr_i; REQ_ADDR = addr_i; REQ_WDATA = data_i;
      PTR_LOAD = ld_i; REQ_INC = inc_i;
      if (!CS_BAR_OUT && !WE_BAR_OUT) sram[SRAM_ADDR] = DQ_OUT;
      if (!CS_BAR_OUT && !OE_BAR_OUT && sram.exists(SRAM_ADDR)) DQ_IN = sram[SRAM_ADDR];
      else DQ_IN = 16'($urandom);
      @(posedge CLK);
      cyc++;
      if (rst_i) begin
         mk = 0; m_rd_data = '0; m_sram_addr = '0; m_ptr = '0;
      end else if (mk == 0) begin
         if (req_i) begin
            mk = 1; m_wr = wr_i; m_data = data_i;
            if (ld_i) begin
               m_addr = addr_i; m_ptr = addr_i + 16'd1;
            end else if (inc_i) begin
               m_addr = m_ptr; m_ptr = m_ptr + 16'd1;
            end else begin
               m_addr = addr_i;
            end
            m_sram_addr = m_addr;
         end else if (ld_i) begin
            m_ptr = addr_i;
         end
      end else if (mk == BUSY) begin
         mk = 0;
      end else begin
         mk++;
      end
      if (!rst_i && mk == 2 && m_wr) ref_mem[m_addr] = m_data;
      if (!rst_i && mk == W + 2 && !m_wr)
         m_rd_data = ref_mem.exists(m_addr) ? ref_mem[m_addr] : 16'hDEAD;
      exp_cs   = !(mk >= 1 && mk <= W + 2);
      exp_we   = !(m_wr && mk >= 2 && mk <= W + 1);
      exp_oe   = !(!m_wr && mk >= 1 && mk <= W + 1);
      exp_dqoe = m_wr && mk >= 1 && mk <= W + 2;
      exp_rv   = !m_wr && mk == W + 2;
      #1;
      if (RD_VALID) rd_pulses++;
      check("cs_bar", 32'(CS_BAR_OUT), 32'(exp_cs));
      check("we_bar", 32'(WE_BAR_OUT), 32'(exp_we));
      check("oe_bar", 32'(OE_BAR_OUT), 32'(exp_oe));
      check("dq_oe", 32'(DQ_OE), 32'(exp_dqoe));
      check("rd_valid", 32'(RD_VALID), 32'(exp_rv));
      check("req_ready", 32'(REQ_READY), 32'(mk == 0));
      check("rd_data", 32'(RD_DATA), 32'(m_rd_data));
      check("we_oe_excl", 32'(WE_BAR_OUT | OE_BAR_OUT), 32'd1);
      check("dqoe_vs_oe", 32'(DQ_OE & !OE_BAR_OUT), 32'd0);
      if (rst_i || !exp_cs) check("sram_addr", 32'(SRAM_ADDR), 32'(m_sram_addr));
      if (exp_dqoe) check("dq_out", 32'(DQ_OUT), 32'(m_data));
      if (rst_i) check("dq_out_rst", 32'(DQ_OUT), 32'd0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
   endtask

   initial begin
      int p0;
      for (int i = 0; i < 8; i++) begin
         sram[pool[i]]    = 16'($urandom);
         ref_mem[pool[i]] = sram[pool[i]];
      end
      sram[16'h00FF]    = 16'hBEEF;
      ref_mem[16'h00FF] = 16'hBEEF;

      // Reset held with a pending request: nothing may start.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 16'h00FF, 16'h1111, 1'b0, 1'b0);
      idle(2);

      // Read of the preloaded word, then write and read back.
      step(1'b0, 1'b1, 1'b0, 16'h00FF, 16'h0000, 1'b0, 1'b0);
      idle(BUSY + 1);
      check("t3_rd_data", 32'(RD_DATA), 32'h0000BEEF);
      step(1'b0, 1'b1, 1'b1, 16'h00FF, 16'h1234, 1'b0, 1'b0);
      idle(BUSY + 1);
      step(1'b0, 1'b1, 1'b0, 16'h00FF, 16'h0000, 1'b0, 1'b0);
      idle(BUSY + 1);
      check("t2_readback", 32'(RD_DATA), 32'h00001234);

      // REQ held high across four back-to-back writes with changing request fields.
      for (int i = 0; i < 4 * (BUSY + 1); i++)
         step(1'b0, 1'b1, 1'b1, pool[i % 8], 16'($urandom), 1'b0, 1'b0);
      idle(BUSY + 1);

      // Reset during the strobe of a read: no read pulse, then a normal read.
      p0 = rd_pulses;
      step(1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      idle(BUSY + 1);
      check("t5_no_rd_valid", 32'(rd_pulses - p0), 32'd0);
      step(1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000, 1'b0, 1'b0);
      idle(BUSY + 1);

`ifdef SRAM_SEQ_AUTOINC_EN
      step(1'b0, 1'b0, 1'b0, 16'hFFFE, 16'h0000, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b1, 16'h5555, 16'($urandom), 1'b0, 1'b1);
         check("t6_autoinc_addr", 32'(SRAM_ADDR), 32'(16'hFFFE + 16'(i)));
         idle(BUSY);
      end
`endif

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 600; i++)
         step(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 7), 1'($urandom),
              pool[$urandom_range(0, 7)], 16'($urandom), 1'b0, 1'b0);
      idle(BUSY + 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
